// File: rtl/bullet_slot_arbiter.sv
// Bullet slot pool shared by two tanks: edge-detected shoot requests, per-tank
// cooldown and in-flight limit, round-robin grant, launch snapshot and slot lifetime.
module bullet_slot_arbiter #(
    parameter int unsigned NUM_SLOTS    = 4,
    parameter int unsigned MAX_PER_TANK = 2,
    parameter int unsigned COOLDOWN     = 15,
    parameter int unsigned LIFETIME     = 300,
    localparam int unsigned SW = (NUM_SLOTS > 1) ? $clog2(NUM_SLOTS) : 1
) (
    input  logic                 frame_clk,
    input  logic                 Reset,
    input  logic [1:0]           game_end,
    input  logic [1:0]           shoot_req,
    input  logic [9:0]           tank0_x,
    input  logic [9:0]           tank0_y,
    input  logic [5:0]           tank0_angle,
    input  logic [9:0]           tank1_x,
    input  logic [9:0]           tank1_y,
    input  logic [5:0]           tank1_angle,
    input  logic [NUM_SLOTS-1:0] slot_kill,
    output logic                 fire_valid,
    output logic [SW-1:0]        fire_slot,
    output logic                 fire_owner,
    output logic [9:0]           fire_x,
    output logic [9:0]           fire_y,
    output logic [5:0]           fire_angle,
    output logic [NUM_SLOTS-1:0] slot_active,
    output logic [NUM_SLOTS-1:0] slot_owner,
    output logic [1:0]           inflight0,
    output logic [1:0]           inflight1,
    output logic [1:0]           cooldown_busy
);
    localparam int unsigned CDW = $clog2(COOLDOWN + 1);
    localparam int unsigned LW  = $clog2(LIFETIME + 1);
    localparam logic [CDW-1:0] CD_INIT   = CDW'(COOLDOWN);
    localparam logic [CDW-1:0] CD_ONE    = CDW'(1);
    localparam logic [LW-1:0]  LIFE_INIT = LW'(LIFETIME);
    localparam logic [LW-1:0]  LIFE_ONE  = LW'(1);
    localparam logic [1:0]     CNT_MAX   = 2'(MAX_PER_TANK);
    localparam logic [1:0]     CNT_ONE   = 2'd1;

    logic [1:0]           r_shoot_q;
    logic [1:0]           r_pending;
    logic                 r_rr;
    logic [CDW-1:0]       r_cd [2];
    logic [1:0]           r_cnt [2];
    logic [LW-1:0]        r_life [NUM_SLOTS];
    logic [NUM_SLOTS-1:0] r_slot_active;
    logic [NUM_SLOTS-1:0] r_slot_owner;
    logic                 r_fire_valid;
    logic [SW-1:0]        r_fire_slot;
    logic                 r_fire_owner;
    logic [9:0]           r_fire_x;
    logic [9:0]           r_fire_y;
    logic [5:0]           r_fire_angle;

    logic [1:0]           w_rise;
    logic [1:0]           w_pend;
    logic [1:0]           w_elig;
    logic                 w_any_free;
    logic                 w_gnt_valid;
    logic                 w_gnt_owner;
    logic [1:0]           w_gnt_tank;
    logic [SW-1:0]        w_slot;
    logic [NUM_SLOTS-1:0] w_slot_oh;
    logic [NUM_SLOTS-1:0] w_retire;
    logic [1:0]           w_ret_cnt [2];
    logic [1:0]           w_cnt_next [2];

    always_comb begin
        w_rise     = shoot_req & ~r_shoot_q;
        w_pend     = r_pending | w_rise;
        w_any_free = ~(&r_slot_active);
        for (int unsigned t = 0; t < 2; t++) begin
            w_elig[t] = w_pend[t] && (r_cd[t] == '0) && (r_cnt[t] < CNT_MAX) && w_any_free;
        end
        w_gnt_valid = |w_elig;
        // Contested grants go to r_rr; otherwise the single eligible tank wins.
        w_gnt_owner = (&w_elig) ? r_rr : ~w_elig[0];
        w_gnt_tank  = w_gnt_valid ? (w_gnt_owner ? 2'b10 : 2'b01) : 2'b00;

        w_slot = '0;
        for (int unsigned s = NUM_SLOTS; s > 0; s--) begin
            if (!r_slot_active[s-1]) w_slot = SW'(s - 1);
        end
        w_slot_oh = '0;
        if (w_gnt_valid) w_slot_oh[w_slot] = 1'b1;

        w_retire     = r_slot_active & slot_kill;
        w_ret_cnt[0] = '0;
        w_ret_cnt[1] = '0;
        for (int unsigned s = 0; s < NUM_SLOTS; s++) begin
            if (r_slot_active[s] && (r_life[s] == LIFE_ONE)) w_retire[s] = 1'b1;
            if (w_retire[s]) begin
                if (r_slot_owner[s]) w_ret_cnt[1] = w_ret_cnt[1] + CNT_ONE;
                else                 w_ret_cnt[0] = w_ret_cnt[0] + CNT_ONE;
            end
        end
        for (int unsigned t = 0; t < 2; t++) begin
            w_cnt_next[t] = r_cnt[t] + {1'b0, w_gnt_tank[t]} - w_ret_cnt[t];
        end
    end

    always_ff @(posedge frame_clk or negedge Reset) begin
        if (!Reset) begin
            r_shoot_q     <= '0;
            r_pending     <= '0;
            r_rr          <= 1'b0;
            r_slot_active <= '0;
            r_slot_owner  <= '0;
            r_fire_valid  <= 1'b0;
            r_fire_slot   <= '0;
            r_fire_owner  <= 1'b0;
            r_fire_x      <= '0;
            r_fire_y      <= '0;
            r_fire_angle  <= '0;
            for (int unsigned t = 0; t < 2; t++) begin
                r_cd[t]  <= '0;
                r_cnt[t] <= '0;
            end
            for (int unsigned s = 0; s < NUM_SLOTS; s++) r_life[s] <= '0;
        end else begin
            r_shoot_q <= shoot_req;
            if (game_end != 2'b00) begin
                r_pending     <= '0;
                r_rr          <= 1'b0;
                r_slot_active <= '0;
                r_fire_valid  <= 1'b0;
                for (int unsigned t = 0; t < 2; t++) begin
                    r_cd[t]  <= '0;
                    r_cnt[t] <= '0;
                end
                for (int unsigned s = 0; s < NUM_SLOTS; s++) r_life[s] <= '0;
            end else begin
                r_pending     <= w_elig & ~w_gnt_tank;
                r_rr          <= (&w_elig) ? ~r_rr : r_rr;
                r_fire_valid  <= w_gnt_valid;
                r_slot_active <= (r_slot_active & ~w_retire) | w_slot_oh;
                if (w_gnt_valid) begin
                    r_fire_slot           <= w_slot;
                    r_fire_owner          <= w_gnt_owner;
                    r_slot_owner[w_slot]  <= w_gnt_owner;
                    r_fire_x     <= w_gnt_owner ? tank1_x     : tank0_x;
                    r_fire_y     <= w_gnt_owner ? tank1_y     : tank0_y;
                    r_fire_angle <= w_gnt_owner ? tank1_angle : tank0_angle;
                end
                for (int unsigned s = 0; s < NUM_SLOTS; s++) begin
                    if (w_slot_oh[s])                          r_life[s] <= LIFE_INIT;
                    else if (r_slot_active[s] && !w_retire[s]) r_life[s] <= r_life[s] - LIFE_ONE;
                    else                                       r_life[s] <= '0;
                end
                for (int unsigned t = 0; t < 2; t++) begin
                    if (w_gnt_tank[t])      r_cd[t] <= CD_INIT;
                    else if (r_cd[t] != '0) r_cd[t] <= r_cd[t] - CD_ONE;
                    r_cnt[t] <= w_cnt_next[t];
                end
            end
        end
    end

    assign fire_valid    = r_fire_valid;
    assign fire_slot     = r_fire_slot;
    assign fire_owner    = r_fire_owner;
    assign fire_x        = r_fire_x;
    assign fire_y        = r_fire_y;
    assign fire_angle    = r_fire_angle;
    assign slot_active   = r_slot_active;
    assign slot_owner    = r_slot_owner;
    assign inflight0     = r_cnt[0];
    assign inflight1     = r_cnt[1];
    assign cooldown_busy = {r_cd[1] != '0, r_cd[0] != '0};

endmodule
